// File: rtl/alu_pkg.sv
// Shared constants, opcode map and FSM state type for the ALU issue controller.
package alu_pkg;

   localparam int unsigned W    = 19;
   localparam int unsigned OPW  = 5;
   localparam int unsigned IMMW = 10;

   localparam logic [4:0] OP_ADD     = 5'b00000;
   localparam logic [4:0] OP_SUB     = 5'b00001;
   localparam logic [4:0] OP_MUL     = 5'b00010;
   localparam logic [4:0] OP_DIV     = 5'b00011;
   localparam logic [4:0] OP_AND     = 5'b00100;
   localparam logic [4:0] OP_OR      = 5'b00101;
   localparam logic [4:0] OP_XOR     = 5'b00110;
   localparam logic [4:0] OP_SHL     = 5'b00111;
   localparam logic [4:0] OP_MAC     = 5'b01000;
   localparam logic [4:0] OP_ADDI    = 5'b01001;
   localparam logic [4:0] OP_SUBI    = 5'b01010;
   localparam logic [4:0] OP_ANDI    = 5'b01011;
   localparam logic [4:0] OP_XORI    = 5'b01100;
   localparam logic [4:0] OP_ORI     = 5'b01101;
   localparam logic [4:0] OP_ACC_CLR = 5'b01110;

   localparam logic [4:0]  ILLEGAL_MIN = 5'b10101;
   localparam logic [18:0] DIV0_RESULT = 19'h7FFFF;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      EXEC    = 2'd1,
      MAC_ADD = 2'd2,
      RESP    = 2'd3
   } state_t;

   // Opcode actually presented to the ALU when a request is accepted.
   function automatic logic [4:0] alu_issue_opcode(input logic [4:0] op);
      if (op == OP_MAC)
         return OP_MUL;
      else if (op == OP_ACC_CLR || op >= ILLEGAL_MIN)
         return OP_ADD;
      else
         return op;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves past the winner on each accept.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] gnt,
   output logic       gnt_id
);

   logic ptr;

   always_comb begin
      gnt_id = ptr;
      if (!req[ptr])
         gnt_id = ~ptr;
      gnt = '0;
      if (en && (|req))
         gnt[gnt_id] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ptr <= 1'b0;
      else if (en && (|req))
         ptr <= ~gnt_id;
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Two-requester issue controller time-sharing one external combinational ALU,
// with two-step MAC against private per-requester accumulators.
module alu_issue_ctrl #(
   parameter int unsigned W    = 19,
   parameter int unsigned OPW  = 5,
   parameter int unsigned IMMW = 10,
   parameter int unsigned TAGW = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [2*OPW-1:0]  req_opcode,
   input  logic [2*W-1:0]    req_op1,
   input  logic [2*W-1:0]    req_op2,
   input  logic [2*IMMW-1:0] req_imm,
   input  logic [2*TAGW-1:0] req_tag,
   output logic [W-1:0]      alu_op1,
   output logic [W-1:0]      alu_op2,
   output logic [OPW-1:0]    alu_opcode,
   output logic [IMMW-1:0]   alu_imm,
   input  logic [W-1:0]      alu_result,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [TAGW-1:0]   rsp_tag,
   output logic [W-1:0]      rsp_data,
   output logic              rsp_err,
   output logic              busy
);

   import alu_pkg::*;

   state_t          state, state_nxt;
   logic [1:0]      gnt;
   logic            gnt_id;
   logic            arb_en;
   logic [OPW-1:0]  cur_op;
   logic [W-1:0]    acc [2];

   logic [OPW-1:0]  sel_opc;
   logic [W-1:0]    sel_op1, sel_op2;
   logic [IMMW-1:0] sel_imm;
   logic [TAGW-1:0] sel_tag;

   rr_arb2 u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req_valid),
      .en     (arb_en),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   always_comb begin
      sel_opc = gnt_id ? req_opcode[2*OPW-1:OPW]   : req_opcode[OPW-1:0];
      sel_op1 = gnt_id ? req_op1[2*W-1:W]          : req_op1[W-1:0];
      sel_op2 = gnt_id ? req_op2[2*W-1:W]          : req_op2[W-1:0];
      sel_imm = gnt_id ? req_imm[2*IMMW-1:IMMW]    : req_imm[IMMW-1:0];
      sel_tag = gnt_id ? req_tag[2*TAGW-1:TAGW]    : req_tag[TAGW-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      arb_en    = (state == IDLE);
      req_ready = gnt;
      rsp_valid = (state == RESP);
      busy      = (state != IDLE);
      unique case (state)
         IDLE:    if (|gnt) state_nxt = EXEC;
         EXEC:    state_nxt = (cur_op == OP_MAC) ? MAC_ADD : RESP;
         MAC_ADD: state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // On the MAC multiply step the ALU operand registers are reloaded with
   // product and accumulator, so the add reads only registered values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_op     <= '0;
         alu_op1    <= '0;
         alu_op2    <= '0;
         alu_opcode <= '0;
         alu_imm    <= '0;
         rsp_id     <= 1'b0;
         rsp_tag    <= '0;
         rsp_data   <= '0;
         rsp_err    <= 1'b0;
         acc[0]     <= '0;
         acc[1]     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (|gnt) begin
                  cur_op     <= sel_opc;
                  rsp_id     <= gnt_id;
                  rsp_tag    <= sel_tag;
                  alu_op1    <= sel_op1;
                  alu_op2    <= sel_op2;
                  alu_imm    <= sel_imm;
                  alu_opcode <= OPW'(alu_issue_opcode(5'(sel_opc)));
               end
            end
            EXEC: begin
               rsp_err  <= 1'b0;
               rsp_data <= alu_result;
               if (cur_op == OPW'(OP_ACC_CLR)) begin
                  rsp_data    <= '0;
                  acc[rsp_id] <= '0;
               end else if (cur_op >= OPW'(ILLEGAL_MIN)) begin
                  rsp_data <= '0;
                  rsp_err  <= 1'b1;
               end else if (cur_op == OPW'(OP_DIV) && alu_op2 == '0) begin
                  rsp_data <= W'(DIV0_RESULT);
                  rsp_err  <= 1'b1;
               end else if (cur_op == OPW'(OP_MAC)) begin
                  alu_op1    <= alu_result;
                  alu_op2    <= acc[rsp_id];
                  alu_opcode <= OPW'(OP_ADD);
               end
            end
            MAC_ADD: begin
               rsp_data    <= alu_result;
               rsp_err     <= 1'b0;
               acc[rsp_id] <= alu_result;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a small behavioural ALU model.
module tb_alu_issue_ctrl;

   localparam logic [4:0] T_ADD  = 5'b00000;
   localparam logic [4:0] T_DIV  = 5'b00011;
   localparam logic [4:0] T_MAC  = 5'b01000;
   localparam logic [4:0] T_SUBI = 5'b01010;
   localparam logic [4:0] T_CLR  = 5'b01110;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req_valid = '0;
   logic [1:0]  req_ready;
   logic [9:0]  req_opcode = '0;
   logic [37:0] req_op1 = '0;
   logic [37:0] req_op2 = '0;
   logic [19:0] req_imm = '0;
   logic [7:0]  req_tag = '0;
   logic [18:0] alu_op1, alu_op2, alu_result;
   logic [4:0]  alu_opcode;
   logic [9:0]  alu_imm;
   logic        rsp_valid, rsp_id, rsp_err, busy;
   logic        rsp_ready = 1'b0;
   logic [3:0]  rsp_tag;
   logic [18:0] rsp_data;

   alu_issue_ctrl #(.W(19), .OPW(5), .IMMW(10), .TAGW(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
      .req_op1(req_op1), .req_op2(req_op2), .req_imm(req_imm), .req_tag(req_tag),
      .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_opcode(alu_opcode), .alu_imm(alu_imm),
      .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
      .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [18:0] simm;
   always_comb begin
      simm = {{9{alu_imm[9]}}, alu_imm};
      case (alu_opcode)
         5'b00000: alu_result = alu_op1 + alu_op2;
         5'b00001: alu_result = alu_op1 - alu_op2;
         5'b00010: alu_result = alu_op1 * alu_op2;
         5'b00011: alu_result = (alu_op2 != '0) ? alu_op1 / alu_op2 : '0;
         5'b01001: alu_result = alu_op1 + simm;
         5'b01010: alu_result = alu_op1 - simm;
         default:  alu_result = '0;
      endcase
   end

   typedef struct {
      logic [4:0]  opc;
      logic [18:0] a;
      logic [18:0] b;
      logic [9:0]  imm;
      logic [3:0]  tag;
      logic [18:0] d;
      logic        e;
   } vec_t;

   typedef struct {
      logic        id;
      logic [3:0]  tag;
      logic [18:0] d;
      logic        e;
      int          acyc;
      int          lat;
   } exp_t;

   vec_t pend0[$];
   vec_t pend1[$];
   exp_t sb[$];
   int   grants[$];
   int   errors = 0;
   int   checks = 0;
   int   stall_req = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic add(input int r, input logic [4:0] opc, input logic [18:0] a,
                      input logic [18:0] b, input logic [9:0] imm, input logic [3:0] tag,
                      input logic [18:0] d, input logic e);
      vec_t v;
      v.opc = opc; v.a = a; v.b = b; v.imm = imm; v.tag = tag; v.d = d; v.e = e;
      if (r == 0) pend0.push_back(v);
      else        pend1.push_back(v);
   endtask

   task automatic push_exp(input logic id, input vec_t v);
      exp_t x;
      x.id = id; x.tag = v.tag; x.d = v.d; x.e = v.e;
      x.acyc = cyc;
      x.lat  = (v.opc == T_MAC) ? 3 : 2;
      sb.push_back(x);
      grants.push_back(int'(id));
   endtask

   // Presents queued vectors per requester until every response has drained.
   task automatic run(input int budget);
      vec_t c0, c1;
      logic a0 = 1'b0;
      logic a1 = 1'b0;
      int   n = 0;
      while ((a0 || a1 || pend0.size() > 0 || pend1.size() > 0 || sb.size() > 0) && n < budget) begin
         @(negedge clk);
         n++;
         if (!a0 && pend0.size() > 0) begin c0 = pend0.pop_front(); a0 = 1'b1; end
         if (!a1 && pend1.size() > 0) begin c1 = pend1.pop_front(); a1 = 1'b1; end
         req_valid  = {a1, a0};
         req_opcode = {c1.opc, c0.opc};
         req_op1    = {c1.a, c0.a};
         req_op2    = {c1.b, c0.b};
         req_imm    = {c1.imm, c0.imm};
         req_tag    = {c1.tag, c0.tag};
         #1;
         if (req_ready != 2'b00)
            check("ready_onehot", 64'(req_ready == 2'b11), 64'(0));
         if (a0 && req_ready[0]) begin
            push_exp(1'b0, c0); a0 = 1'b0;
         end else if (a1 && req_ready[1]) begin
            push_exp(1'b1, c1); a1 = 1'b0;
         end
      end
      if (n >= budget) begin
         checks++; errors++;
         $display("FAIL run_timeout: got pending=%0d expected 0", sb.size() + pend0.size() + pend1.size());
         pend0.delete(); pend1.delete(); sb.delete();
      end
      @(negedge clk);
      req_valid = '0;
   endtask

   // Monitor: compares the head expectation every cycle rsp_valid is high,
   // which also proves the payload holds while rsp_ready is low.
   initial begin
      exp_t e;
      int   hold = 0;
      logic seen = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            seen = 1'b0;
            rsp_ready = 1'b0;
         end else if (rsp_valid) begin
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_rsp: got data=%0h expected no response", rsp_data);
               rsp_ready = 1'b1;
            end else begin
               e = sb[0];
               if (!seen) begin
                  seen = 1'b1;
                  hold = stall_req;
                  check("latency", 64'(cyc - e.acyc), 64'(e.lat));
               end
               check("payload", 64'({rsp_id, rsp_tag, rsp_data, rsp_err}),
                                64'({e.id, e.tag, e.d, e.e}));
               if (hold > 0) begin
                  hold--;
                  rsp_ready = 1'b0;
               end else begin
                  rsp_ready = 1'b1;
                  void'(sb.pop_front());
                  seen = 1'b0;
               end
            end
         end else begin
            rsp_ready = 1'b0;
         end
      end
   end

   initial begin
      int exp_g[4];
      exp_g = '{0, 1, 0, 1};

      // reset state
      repeat (2) @(negedge clk);
      check("rst_ctrl", 64'({req_ready, rsp_valid, busy}), 64'(0));
      check("rst_alu",  64'({alu_opcode, alu_op1, alu_op2}), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // contention fairness with a 3-cycle response stall
      stall_req = 3;
      grants.delete();
      add(0, T_ADD, 19'd1,  19'd1, 10'd0, 4'd1, 19'd2,  1'b0);
      add(0, T_ADD, 19'd2,  19'd2, 10'd0, 4'd2, 19'd4,  1'b0);
      add(1, T_ADD, 19'd10, 19'd1, 10'd0, 4'd5, 19'd11, 1'b0);
      add(1, T_ADD, 19'd20, 19'd2, 10'd0, 4'd6, 19'd22, 1'b0);
      run(300);
      stall_req = 0;
      check("grant_count", 64'(grants.size()), 64'(4));
      for (int i = 0; i < 4; i++)
         if (i < grants.size())
            check($sformatf("grant_order_%0d", i), 64'(grants[i]), 64'(exp_g[i]));

      // single ADD
      add(0, T_ADD, 19'd5, 19'd7, 10'd0, 4'd3, 19'd12, 1'b0);
      run(50);

      // MAC accumulation and accumulator isolation
      add(1, T_MAC, 19'd3, 19'd4, 10'd0, 4'd7, 19'd12, 1'b0);
      add(1, T_MAC, 19'd2, 19'd5, 10'd0, 4'd8, 19'd22, 1'b0);
      run(100);
      add(0, T_MAC, 19'd1, 19'd1, 10'd0, 4'd4, 19'd1, 1'b0);
      run(50);
      add(1, T_CLR, 19'd0, 19'd0, 10'd0, 4'd9, 19'd0, 1'b0);
      add(1, T_MAC, 19'd1, 19'd1, 10'd0, 4'hA, 19'd1, 1'b0);
      run(100);

      // divide-by-zero, normal divide, illegal opcode
      add(0, T_DIV,    19'd9, 19'd0, 10'd0, 4'hB, 19'h7FFFF, 1'b1);
      add(0, T_DIV,    19'd9, 19'd2, 10'd0, 4'hC, 19'd4,     1'b0);
      add(0, 5'b11000, 19'd9, 19'd2, 10'd0, 4'hD, 19'd0,     1'b1);
      run(100);

      // modulo wrap
      add(1, T_ADD,  19'h7FFFF, 19'd1, 10'd0,     4'hE, 19'd0, 1'b0);
      add(1, T_SUBI, 19'd0,     19'd0, 10'h3FF,   4'hF, 19'd1, 1'b0);
      run(100);

      // reset while in MAC_ADD abandons the op and clears accumulators
      @(negedge clk);
      req_valid  = 2'b10;
      req_opcode = {T_MAC, 5'd0};
      req_op1    = {19'd5, 19'd0};
      req_op2    = {19'd5, 19'd0};
      req_imm    = '0;
      req_tag    = {4'd9, 4'd0};
      #1;
      check("midop_grant", 64'(req_ready), 64'(2'b10));
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      check("midop_busy", 64'({busy, rsp_valid}), 64'(2'b10));
      #2 rst_n = 1'b0;
      #1;
      check("rst_async", 64'({busy, rsp_valid, alu_opcode}), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      add(1, T_MAC, 19'd2, 19'd3, 10'd0, 4'd2, 19'd6, 1'b0);
      run(100);

      repeat (3) @(negedge clk);
      check("sb_empty", 64'(sb.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Two-requester issue controller that time-shares one 19-bit combinational ALU (5-bit opcode, 10-bit sign-extended immediate).
- Arbitrates round-robin between the requesters and drives ALU operands and opcode from registers.
- Implements MAC as a two-step multiply-then-add against a per-requester accumulator, so the ALU is never used in a combinational feedback loop.
- Screens divide-by-zero and illegal opcodes, then returns a tagged result over a valid/ready response channel.

Parameters:
- W, 19, datapath width.
- OPW, 5, opcode width.
- IMMW, 10, immediate width.
- TAGW, 4, requester tag width, echoed unchanged in the response.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester request valid; [0] is requester 0.
- req_ready  out  2  per-requester accept; one-hot or zero.
- req_opcode  in  2*OPW  per-requester opcode; [OPW-1:0] belongs to requester 0.
- req_op1  in  2*W  per-requester operand 1.
- req_op2  in  2*W  per-requester operand 2.
- req_imm  in  2*IMMW  per-requester immediate.
- req_tag  in  2*TAGW  per-requester tag.
- alu_op1, alu_op2  out  W  registered ALU operands.
- alu_opcode  out  OPW  registered ALU opcode.
- alu_imm  out  IMMW  registered ALU immediate.
- alu_result  in  W  combinational ALU result.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  1  requester index of the response.
- rsp_tag  out  TAGW  echoed tag.
- rsp_data  out  W  result.
- rsp_err  out  1  divide-by-zero or illegal opcode.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset state:
  - All outputs and registers are 0 on reset: req_ready=0, rsp_valid=0, both accumulators=0, rr pointer=0, state=IDLE, alu_opcode=0.
  - Reset is asynchronous; when asserted mid-operation it abandons the operation and drops rsp_valid with no response produced.
- FSM states: IDLE, EXEC, MAC_ADD, RESP.
- IDLE:
  - If any req_valid is high, grant one requester: the pointer requester wins if both are valid.
  - req_ready for the granted index is asserted combinationally in IDLE; the transfer occurs on that edge.
  - On the transfer, latch opcode/op1/op2/imm/tag/id and toggle the pointer to the other index.
  - Next state is EXEC.
- EXEC (one cycle): ALU inputs hold the latched values, and the result is captured at the end of the cycle.
  - 01110 (ACC_CLR): controller-local opcode, never presented to the ALU (alu_opcode driven 00000). Clears that requester's accumulator; rsp_data=0, rsp_err=0.
  - 00011 with op2==0: ALU result ignored; rsp_data=19'h7FFFF, rsp_err=1.
  - 10101..11111: rsp_data=0, rsp_err=1, no ALU use.
  - 01000 (MAC): alu_opcode is driven 00010 (MUL); the product is captured and the next state is MAC_ADD.
  - All other opcodes: rsp_data=alu_result, rsp_err=0.
  - Next state is RESP for every opcode except MAC.
- MAC_ADD (one cycle):
  - Drive alu_opcode=00000, alu_op1=product, alu_op2=acc[id].
  - Capture the sum into both rsp_data and acc[id].
  - Next state is RESP.
- RESP:
  - rsp_valid=1; payload holds stable until rsp_ready.
  - On rsp_valid&&rsp_ready, go to IDLE. No new grant happens in that same cycle.
- Latency: accept edge to rsp_valid is 2 cycles (3 for MAC). Throughput is one op per 3 cycles at best.
- Arithmetic: all results are truncated modulo 2^W with no overflow flag; the MAC product is truncated before the add.
- Accumulator overflow wraps silently.
- Each requester's accumulator is private: MAC and ACC_CLR from requester 1 never touch acc[0].
- Branch opcodes 01111/10000 return 1/0 in rsp_data; the controller takes no branch action.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams (OP_ADD..OP_ORI, OP_ACC_CLR=5'b01110);
  - the FSM state enum;
  - W/OPW/IMMW constants;
  - ILLEGAL_MIN=5'b10101;
  - DIV0_RESULT=19'h7FFFF.
- One sub-module, rr_arb2: 2-way round-robin grant with pointer update on accept.

Test Plan:
- Single ADD: req0 opcode 00000, op1=5, op2=7, tag=3. Expect rsp_data=12, id=0, tag=3, err=0; rsp_valid exactly 2 cycles after accept.
- Contention fairness: both requesters continuously valid with ADD. Expect grants alternating 0,1,0,1 over 4 ops; rsp_ready held low for 3 cycles keeps the payload stable.
- MAC accumulate: req1 MAC (3,4), then MAC (2,5). Expect rsp_data 12 then 22; a following req0 MAC (1,1) returns 1, confirming isolated accumulators; ACC_CLR on req1 then MAC (1,1) returns 1.
- Div-by-zero and illegal opcodes:
  - DIV op1=9, op2=0: rsp_data=19'h7FFFF, err=1.
  - DIV 9/2: rsp_data=4, err=0.
  - opcode 11000: rsp_data=0, err=1.
- Wrap: ADD 19'h7FFFF+1 returns 0; SUBI op1=0, imm=10'h3FF (-1) returns 1.
- Reset mid-op: assert rst_n low while in MAC_ADD. Expect rsp_valid=0 and busy=0 immediately; after release, MAC (2,3) returns 6, proving acc was cleared.
